// File: rtl/sms_bus_responder_pkg.sv
// Shared definitions for the Sega-mapper bus responder.
// Covers FSM state codes, backend select codes, mapper register addresses and region bounds.
package sms_bus_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [1:0] SEL_ROM    = 2'd0;
    localparam logic [1:0] SEL_SYSRAM = 2'd1;
    localparam logic [1:0] SEL_CART   = 2'd2;

    localparam logic [15:0] MAP_CTRL  = 16'hFFFC;
    localparam logic [15:0] MAP_SLOT0 = 16'hFFFD;
    localparam logic [15:0] MAP_SLOT1 = 16'hFFFE;
    localparam logic [15:0] MAP_SLOT2 = 16'hFFFF;

    // First address past the unpaged low ROM window.
    localparam logic [15:0] FIXED_TOP = 16'h0400;

    localparam logic [1:0] REGION_SLOT0 = 2'b00;
    localparam logic [1:0] REGION_SLOT1 = 2'b01;
    localparam logic [1:0] REGION_SLOT2 = 2'b10;
    localparam logic [1:0] REGION_RAM   = 2'b11;

endpackage

// File: rtl/sms_bus_responder_mapper_regs.sv
// Sega mapper control/slot registers and core-address to physical-address decode.
// Decode is combinational (0 cycles); register writes take effect on the next clock.
// No flow control: the write port is a single-cycle enable.
module sms_mapper_regs #(
    parameter int PAGE_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [1:0]             wr_idx,
    input  logic [7:0]             wr_data,
    input  logic [15:0]            addr,
    output logic [1:0]             sel,
    output logic [PAGE_BITS+13:0]  phys_addr
);
    import sms_bus_responder_pkg::*;

    localparam int AW = PAGE_BITS + 14;

    // Only ctrl[3] (cart RAM enable) and ctrl[2] (cart RAM bank) affect decode.
    logic                 ram_en_q, ram_en_d;
    logic                 ram_bank_q, ram_bank_d;
    logic [PAGE_BITS-1:0] slot0_q, slot0_d;
    logic [PAGE_BITS-1:0] slot1_q, slot1_d;
    logic [PAGE_BITS-1:0] slot2_q, slot2_d;

    always_comb begin
        ram_en_d   = ram_en_q;
        ram_bank_d = ram_bank_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        slot2_d    = slot2_q;
        if (wr_en) begin
            case (wr_idx)
                2'd0: begin
                    ram_en_d   = wr_data[3];
                    ram_bank_d = wr_data[2];
                end
                2'd1:    slot0_d = PAGE_BITS'(wr_data);
                2'd2:    slot1_d = PAGE_BITS'(wr_data);
                default: slot2_d = PAGE_BITS'(wr_data);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en_q   <= 1'b0;
            ram_bank_q <= 1'b0;
            slot0_q    <= PAGE_BITS'(0);
            slot1_q    <= PAGE_BITS'(1);
            slot2_q    <= PAGE_BITS'(2);
        end else begin
            ram_en_q   <= ram_en_d;
            ram_bank_q <= ram_bank_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            slot2_q    <= slot2_d;
        end
    end

    always_comb begin
        sel       = SEL_ROM;
        phys_addr = '0;
        if (addr < FIXED_TOP) begin
            phys_addr = AW'(addr[13:0]);
        end else begin
            case (addr[15:14])
                REGION_SLOT0: phys_addr = {slot0_q, addr[13:0]};
                REGION_SLOT1: phys_addr = {slot1_q, addr[13:0]};
                REGION_SLOT2: begin
                    if (ram_en_q) begin
                        sel       = SEL_CART;
                        phys_addr = AW'({ram_bank_q, addr[13:0]});
                    end else begin
                        phys_addr = {slot2_q, addr[13:0]};
                    end
                end
                default: begin
                    // 8 KB system RAM, mirrored across C000-FFFF.
                    sel       = SEL_SYSRAM;
                    phys_addr = AW'(addr[12:0]);
                end
            endcase
        end
    end

endmodule

// File: rtl/sms_bus_responder.sv
// Core data-bus target: decodes requests, applies the mapper, forwards to memory or I/O backends.
// Latency: 3 cycles minimum (request, one ACCESS with ack, DONE); ROM writes complete in 2.
// Backpressure: D_wait stalls the core until backend ack or TIMEOUT_CYC cycles elapse.
module sms_bus_responder #(
    parameter int TIMEOUT_CYC = 64,
    parameter int PAGE_BITS   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [15:0]           D_addr,
    input  logic [7:0]            D_data_out,
    input  logic                  MREQ,
    input  logic                  IORQ,
    input  logic                  RD,
    input  logic                  WR,
    output logic [7:0]            D_data_in,
    output logic                  D_wait,
    output logic                  M_req,
    output logic                  M_we,
    output logic [1:0]            M_sel,
    output logic [PAGE_BITS+13:0] M_addr,
    output logic [7:0]            M_wdata,
    input  logic [7:0]            M_rdata,
    input  logic                  M_ack,
    output logic                  P_req,
    output logic                  P_we,
    output logic [7:0]            P_addr,
    output logic [7:0]            P_wdata,
    input  logic [7:0]            P_rdata,
    input  logic                  P_ack,
    output logic                  bus_err
);
    import sms_bus_responder_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e                 state_q, state_d;
    logic                   is_mem_q, is_mem_d;
    logic                   is_wr_q, is_wr_d;
    logic [15:0]            addr_q, addr_d;
    logic                   m_req_q, m_req_d;
    logic                   m_we_q, m_we_d;
    logic [1:0]             m_sel_q, m_sel_d;
    logic [PAGE_BITS+13:0]  m_addr_q, m_addr_d;
    logic [7:0]             m_wdata_q, m_wdata_d;
    logic                   p_req_q, p_req_d;
    logic                   p_we_q, p_we_d;
    logic [7:0]             p_addr_q, p_addr_d;
    logic [7:0]             p_wdata_q, p_wdata_d;
    logic [7:0]             d_data_in_q, d_data_in_d;
    logic                   bus_err_q, bus_err_d;
    logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;

    logic                   req_present;
    logic                   map_wr_en;
    logic [1:0]             map_sel;
    logic [PAGE_BITS+13:0]  map_addr;
    logic                   ack;
    logic [7:0]             rdata;

    assign req_present = (MREQ | IORQ) & (RD | WR);
    assign ack         = is_mem_q ? M_ack : P_ack;
    assign rdata       = is_mem_q ? M_rdata : P_rdata;
    // Mapper registers commit at the end of DONE so the new paging applies from the next IDLE.
    assign map_wr_en   = (state_q == ST_DONE) & is_mem_q & is_wr_q & (addr_q >= MAP_CTRL);

    sms_mapper_regs #(.PAGE_BITS(PAGE_BITS)) u_mapper (
        .clk       (CLK),
        .rst       (RST),
        .wr_en     (map_wr_en),
        .wr_idx    (addr_q[1:0]),
        .wr_data   (m_wdata_q),
        .addr      (D_addr),
        .sel       (map_sel),
        .phys_addr (map_addr)
    );

    always_comb begin
        state_d     = state_q;
        is_mem_d    = is_mem_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_sel_d     = m_sel_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        p_req_d     = p_req_q;
        p_we_d      = p_we_q;
        p_addr_d    = p_addr_q;
        p_wdata_d   = p_wdata_q;
        d_data_in_d = 8'hFF;
        bus_err_d   = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_present) begin
                    addr_d   = D_addr;
                    is_mem_d = MREQ;
                    is_wr_d  = WR;
                    if (MREQ && WR && map_sel == SEL_ROM) begin
                        state_d = ST_DONE;
                    end else if (MREQ) begin
                        m_req_d   = 1'b1;
                        m_we_d    = WR;
                        m_sel_d   = map_sel;
                        m_addr_d  = map_addr;
                        m_wdata_d = D_data_out;
                        tmo_cnt_d = '0;
                        state_d   = ST_ACCESS;
                    end else begin
                        p_req_d   = 1'b1;
                        p_we_d    = WR;
                        p_addr_d  = D_addr[7:0];
                        p_wdata_d = D_data_out;
                        tmo_cnt_d = '0;
                        state_d   = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (ack) begin
                    m_req_d     = 1'b0;
                    p_req_d     = 1'b0;
                    d_data_in_d = is_wr_q ? 8'hFF : rdata;
                    state_d     = ST_DONE;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    m_req_d   = 1'b0;
                    p_req_d   = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            is_mem_q    <= 1'b0;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_sel_q     <= SEL_ROM;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            p_req_q     <= 1'b0;
            p_we_q      <= 1'b0;
            p_addr_q    <= '0;
            p_wdata_q   <= '0;
            d_data_in_q <= 8'hFF;
            bus_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            is_mem_q    <= is_mem_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_sel_q     <= m_sel_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            p_req_q     <= p_req_d;
            p_we_q      <= p_we_d;
            p_addr_q    <= p_addr_d;
            p_wdata_q   <= p_wdata_d;
            d_data_in_q <= d_data_in_d;
            bus_err_q   <= bus_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign D_wait    = req_present & (state_q != ST_DONE);
    assign D_data_in = d_data_in_q;
    assign M_req     = m_req_q;
    assign M_we      = m_we_q;
    assign M_sel     = m_sel_q;
    assign M_addr    = m_addr_q;
    assign M_wdata   = m_wdata_q;
    assign P_req     = p_req_q;
    assign P_we      = p_we_q;
    assign P_addr    = p_addr_q;
    assign P_wdata   = p_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_sms_bus_responder.sv
// Directed bench for sms_bus_responder: table of mapped memory transactions plus corner sequences.
module tb_sms_bus_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] D_addr;
    logic [7:0]  D_data_out;
    logic        MREQ, IORQ, RD, WR;
    logic [7:0]  D_data_in;
    logic        D_wait;
    logic        M_req, M_we;
    logic [1:0]  M_sel;
    logic [21:0] M_addr;
    logic [7:0]  M_wdata;
    logic [7:0]  M_rdata;
    logic        M_ack;
    logic        P_req, P_we;
    logic [7:0]  P_addr, P_wdata, P_rdata;
    logic        P_ack;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    sms_bus_responder #(.TIMEOUT_CYC(64), .PAGE_BITS(8)) dut (
        .CLK(CLK), .RST(RST), .D_addr(D_addr), .D_data_out(D_data_out),
        .MREQ(MREQ), .IORQ(IORQ), .RD(RD), .WR(WR),
        .D_data_in(D_data_in), .D_wait(D_wait),
        .M_req(M_req), .M_we(M_we), .M_sel(M_sel), .M_addr(M_addr),
        .M_wdata(M_wdata), .M_rdata(M_rdata), .M_ack(M_ack),
        .P_req(P_req), .P_we(P_we), .P_addr(P_addr), .P_wdata(P_wdata),
        .P_rdata(P_rdata), .P_ack(P_ack), .bus_err(bus_err)
    );

    typedef struct {
        logic        mreq, iorq, rd, wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic [1:0]  exp_sel;
        logic [21:0] exp_maddr;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic drive(input logic mreq, input logic iorq, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [7:0] wdata);
        MREQ = mreq; IORQ = iorq; RD = rd; WR = wr;
        D_addr = addr; D_data_out = wdata;
    endtask

    // Memory transaction acked in the first ACCESS cycle.
    task automatic apply_vec(input string tag, input vec_t v);
        step();
        drive(v.mreq, v.iorq, v.rd, v.wr, v.addr, v.wdata);
        smp();
        chk({tag, ".wait0"}, D_wait, 1);
        step();
        M_ack = 1'b1; M_rdata = v.rdata;
        smp();
        chk({tag, ".wait1"}, D_wait, 1);
        chk({tag, ".mreq"}, M_req, 1);
        chk({tag, ".preq"}, P_req, 0);
        chk({tag, ".sel"}, M_sel, v.exp_sel);
        chk({tag, ".maddr"}, M_addr, v.exp_maddr);
        chk({tag, ".mwe"}, M_we, v.wr);
        if (v.wr) chk({tag, ".wdata"}, M_wdata, v.wdata);
        step();
        M_ack = 1'b0;
        smp();
        chk({tag, ".wait2"}, D_wait, 0);
        chk({tag, ".dout"}, D_data_in, v.exp_dout);
        chk({tag, ".mreq_drop"}, M_req, 0);
        chk({tag, ".berr"}, bus_err, 0);
        step();
        drive(0, 0, 0, 0, 16'h0000, 8'h00);
        smp();
        chk({tag, ".dout_idle"}, D_data_in, 8'hFF);
    endtask

    initial begin
        int hi;
        vec_t pv;

        //          mreq iorq rd wr addr      wdata  rdata  sel   maddr         dout
        vecs[0]  = '{1, 0, 1, 0, 16'h0123, 8'h00, 8'h5A, 2'd0, 22'h000123, 8'h5A};
        vecs[1]  = '{1, 0, 1, 0, 16'h0400, 8'h00, 8'h11, 2'd0, 22'h000400, 8'h11};
        vecs[2]  = '{1, 0, 1, 0, 16'h4567, 8'h00, 8'h22, 2'd0, 22'h004567, 8'h22};
        vecs[3]  = '{1, 0, 1, 0, 16'h9ABC, 8'h00, 8'h33, 2'd0, 22'h009ABC, 8'h33};
        vecs[4]  = '{1, 0, 1, 0, 16'hE123, 8'h00, 8'h44, 2'd1, 22'h000123, 8'h44};
        vecs[5]  = '{1, 1, 1, 1, 16'hC010, 8'h66, 8'h00, 2'd1, 22'h000010, 8'hFF};
        vecs[6]  = '{1, 0, 0, 1, 16'hFFFF, 8'h05, 8'h00, 2'd1, 22'h001FFF, 8'hFF};
        vecs[7]  = '{1, 0, 1, 0, 16'h8010, 8'h00, 8'h55, 2'd0, 22'h014010, 8'h55};
        vecs[8]  = '{1, 0, 0, 1, 16'hFFFC, 8'h08, 8'h00, 2'd1, 22'h001FFC, 8'hFF};
        vecs[9]  = '{1, 0, 1, 0, 16'h8001, 8'h00, 8'h66, 2'd2, 22'h000001, 8'h66};
        vecs[10] = '{1, 0, 0, 1, 16'hFFFC, 8'h0C, 8'h00, 2'd1, 22'h001FFC, 8'hFF};
        vecs[11] = '{1, 0, 1, 0, 16'h8001, 8'h00, 8'h77, 2'd2, 22'h004001, 8'h77};
        vecs[12] = '{1, 0, 0, 1, 16'hFFFD, 8'h03, 8'h00, 2'd1, 22'h001FFD, 8'hFF};
        vecs[13] = '{1, 0, 1, 0, 16'h03FF, 8'h00, 8'h88, 2'd0, 22'h0003FF, 8'h88};
        vecs[14] = '{1, 0, 1, 0, 16'h0400, 8'h00, 8'h99, 2'd0, 22'h00C400, 8'h99};
        vecs[15] = '{1, 0, 0, 1, 16'hFFFE, 8'h7F, 8'h00, 2'd1, 22'h001FFE, 8'hFF};
        vecs[16] = '{1, 0, 1, 0, 16'h7FFF, 8'h00, 8'hAA, 2'd0, 22'h1FFFFF, 8'hAA};
        vecs[17] = '{1, 0, 0, 1, 16'hFFFC, 8'h00, 8'h00, 2'd1, 22'h001FFC, 8'hFF};
        vecs[18] = '{1, 0, 1, 0, 16'hBFFF, 8'h00, 8'hBB, 2'd0, 22'h017FFF, 8'hBB};

        RST = 1'b1;
        drive(0, 0, 0, 0, 16'h0000, 8'h00);
        M_ack = 1'b0; M_rdata = 8'h00; P_ack = 1'b0; P_rdata = 8'h00;
        repeat (3) step();
        RST = 1'b0;
        smp();
        chk("rst.wait", D_wait, 0);
        chk("rst.dout", D_data_in, 8'hFF);
        chk("rst.mreq", M_req, 0);
        chk("rst.preq", P_req, 0);
        chk("rst.mwe", M_we, 0);
        chk("rst.msel", M_sel, 0);
        chk("rst.maddr", M_addr, 0);
        chk("rst.paddr", P_addr, 0);
        chk("rst.berr", bus_err, 0);

        for (int i = 0; i < 19; i++)
            apply_vec($sformatf("vec%0d", i), vecs[i]);

        // I/O write, ack in the 5th ACCESS cycle.
        step();
        drive(0, 1, 0, 1, 16'h127F, 8'h9F);
        smp();
        hi = D_wait ? 1 : 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 5) P_ack = 1'b1;
            smp();
            if (D_wait) hi++;
            if (k == 1 || k == 5) begin
                chk($sformatf("iow.preq%0d", k), P_req, 1);
                chk($sformatf("iow.paddr%0d", k), P_addr, 8'h7F);
                chk($sformatf("iow.pwe%0d", k), P_we, 1);
                chk($sformatf("iow.pwdata%0d", k), P_wdata, 8'h9F);
                chk($sformatf("iow.mreq%0d", k), M_req, 0);
            end
        end
        step();
        P_ack = 1'b0;
        smp();
        chk("iow.wait_done", D_wait, 0);
        chk("iow.preq_drop", P_req, 0);
        chk("iow.wait_cycles", hi, 6);
        step();
        drive(0, 0, 0, 0, 16'h0000, 8'h00);

        // I/O read.
        step();
        drive(0, 1, 1, 0, 16'hAB42, 8'h00);
        smp();
        step();
        P_ack = 1'b1; P_rdata = 8'hA5;
        smp();
        chk("ior.preq", P_req, 1);
        chk("ior.pwe", P_we, 0);
        chk("ior.paddr", P_addr, 8'h42);
        step();
        P_ack = 1'b0;
        smp();
        chk("ior.wait", D_wait, 0);
        chk("ior.dout", D_data_in, 8'hA5);
        step();
        drive(0, 0, 0, 0, 16'h0000, 8'h00);

        // IORQ without a strobe is not a request.
        step();
        drive(0, 1, 0, 0, 16'h0011, 8'h00);
        smp();
        chk("iorq_nostrobe.wait", D_wait, 0);
        step();
        smp();
        chk("iorq_nostrobe.preq", P_req, 0);
        step();
        drive(0, 0, 0, 0, 16'h0000, 8'h00);

        // Write to ROM: dropped, completes in 2 cycles.
        step();
        drive(1, 0, 0, 1, 16'h2000, 8'hAB);
        smp();
        chk("romwr.wait0", D_wait, 1);
        step();
        smp();
        chk("romwr.wait1", D_wait, 0);
        chk("romwr.mreq", M_req, 0);
        chk("romwr.dout", D_data_in, 8'hFF);
        step();
        drive(0, 0, 0, 0, 16'h0000, 8'h00);

        // Timeout with no ack, bounded wait.
        step();
        drive(1, 0, 1, 0, 16'h0200, 8'h00);
        hi = 0;
        smp();
        for (int n = 0; n < 200; n++) begin
            if (!D_wait) break;
            hi++;
            step();
            smp();
        end
        chk("tmo.wait_cycles", hi, 65);
        chk("tmo.dout", D_data_in, 8'hFF);
        chk("tmo.berr", bus_err, 1);
        chk("tmo.mreq", M_req, 0);
        step();
        drive(0, 0, 0, 0, 16'h0000, 8'h00);
        M_ack = 1'b1; M_rdata = 8'h12;
        smp();
        chk("tmo.berr_pulse", bus_err, 0);
        chk("late_ack.dout", D_data_in, 8'hFF);
        chk("late_ack.mreq", M_req, 0);
        chk("late_ack.wait", D_wait, 0);
        step();
        M_ack = 1'b0;

        // Reset in the middle of ACCESS.
        step();
        drive(1, 0, 1, 0, 16'hC005, 8'h00);
        smp();
        step();
        smp();
        chk("rstmid.mreq_before", M_req, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        drive(0, 0, 0, 0, 16'h0000, 8'h00);
        smp();
        chk("rstmid.mreq", M_req, 0);
        chk("rstmid.wait", D_wait, 0);
        chk("rstmid.dout", D_data_in, 8'hFF);

        // Fresh 3-cycle transaction after reset with default mapper state.
        pv = '{1, 0, 1, 0, 16'h9ABC, 8'h00, 8'hC3, 2'd0, 22'h009ABC, 8'hC3};
        apply_vec("post_rst_slot2", pv);
        pv = '{1, 0, 1, 0, 16'h8001, 8'h00, 8'h3C, 2'd0, 22'h008001, 8'h3C};
        apply_vec("post_rst_ctrl", pv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

endmodule
